// File: rtl/spw_fc_pkg.sv
// Shared constants and FSM state type for the SpaceWire RX flow-control scheduler.
// Contents: FCT_SIZE, CREDIT_MAX, INIT_PENDING, counter widths, fct_state_e.
package spw_fc_pkg;

  localparam int unsigned FCT_SIZE     = 8;
  localparam int unsigned CREDIT_MAX   = 56;
  localparam int unsigned INIT_PENDING = CREDIT_MAX / FCT_SIZE;
  localparam int unsigned CWIDTH       = 6;
  localparam int unsigned PWIDTH       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    UPDATE = 2'd2
  } fct_state_e;

endpackage

// File: rtl/rx_credit_counter.sv
// Credit granted to the far end: saturating up/down counter and sticky credit error.
// Ports:
//   clock, reset      clock and asynchronous active-low reset
//   clear             synchronous clear (link ErrorReset); overrides add8/sub1
//   add8              grant FCT_SIZE more credit (FCT committed)
//   sub1              one N-char received
//   credit            current outstanding credit
//   credit_error      sticky: a char arrived while credit was zero
module rx_credit_counter
  import spw_fc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add8,
  input  logic              sub1,
  output logic [CWIDTH-1:0] credit,
  output logic              credit_error
);

  localparam logic [CWIDTH-1:0] STEP = CWIDTH'(FCT_SIZE);
  localparam logic [CWIDTH-1:0] MAX  = CWIDTH'(CREDIT_MAX);
  localparam logic [CWIDTH-1:0] ONE  = CWIDTH'(1);

  logic [CWIDTH-1:0] credit_q, credit_d;
  logic              error_q, error_d;

  // Next credit/error value
  always_comb begin
    credit_d = credit_q;
    error_d  = error_q;
    if (clear) begin
      credit_d = '0;
      error_d  = 1'b0;
    end else if (add8) begin
      // A char arriving with a grant is drawn from the fresh grant, so no error
      if (credit_q > MAX - STEP) begin
        credit_d = MAX;
      end else begin
        credit_d = credit_q + STEP;
      end
      if (sub1) begin
        credit_d = credit_d - ONE;
      end
    end else if (sub1) begin
      if (credit_q == '0) begin
        error_d = 1'b1;
      end else begin
        credit_d = credit_q - ONE;
      end
    end
  end

  // Credit registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      credit_q <= '0;
      error_q  <= 1'b0;
    end else begin
      credit_q <= credit_d;
      error_q  <= error_d;
    end
  end

  assign credit       = credit_q;
  assign credit_error = error_q;

endmodule

// File: rtl/rx_fct_scheduler.sv
// SpaceWire RX flow-control scheduler: tracks credit granted to the far end,
// counts FCTs owed for freed RX FIFO slots and requests FCTs from the TX encoder.
// Optional macro RX_FCT_STATS_EN adds fct_sent_count (16-bit wrapping count of sent FCTs).
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   link_enable         link in Connecting/Run; FCT requests allowed
//   link_reset          synchronous clear to post-reset values, highest priority
//   rx_char_valid       one pulse per received N-char
//   slot_free           RX FIFO level; each rising edge frees FCT_SIZE slots
//   fct_req / fct_ack   FCT request handshake with the TX encoder
//   outstanding_credit  credit currently granted to the far end
//   pending_fct         FCTs owed but not yet sent (saturating)
//   credit_error        sticky; char received with zero credit
module rx_fct_scheduler
  import spw_fc_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              link_enable,
  input  logic              link_reset,
  input  logic              rx_char_valid,
  input  logic              slot_free,
  output logic              fct_req,
  input  logic              fct_ack,
  output logic [CWIDTH-1:0] outstanding_credit,
  output logic [PWIDTH-1:0] pending_fct,
  output logic              credit_error
`ifdef RX_FCT_STATS_EN
  ,
  output logic [15:0]       fct_sent_count
`endif
);

  localparam logic [CWIDTH-1:0] REQ_LIMIT = CWIDTH'(CREDIT_MAX - FCT_SIZE);
  localparam logic [PWIDTH-1:0] PEND_INIT = PWIDTH'(INIT_PENDING);
  localparam logic [PWIDTH-1:0] PEND_SAT  = {PWIDTH{1'b1}};
  localparam logic [PWIDTH-1:0] PEND_ONE  = PWIDTH'(1);

  fct_state_e        state_q;
  logic              fct_req_q;
  logic              slot_free_q;
  logic [PWIDTH-1:0] pending_q, pending_d;
  logic              slot_edge;
  logic              in_update;
  logic              can_request;

  assign slot_edge   = slot_free & ~slot_free_q;
  assign in_update   = (state_q == UPDATE);
  // Only ask for an FCT when its grant still fits under CREDIT_MAX
  assign can_request = link_enable && (pending_q != '0) && (outstanding_credit <= REQ_LIMIT);

  // Request FSM; fct_req is registered alongside the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fct_req_q <= 1'b0;
    end else if (link_reset) begin
      state_q   <= IDLE;
      fct_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (can_request) begin
            state_q   <= REQ;
            fct_req_q <= 1'b1;
          end
        end
        REQ: begin
          // An ack in the same cycle as link drop still commits the FCT
          if (fct_ack) begin
            state_q   <= UPDATE;
            fct_req_q <= 1'b0;
          end else if (!link_enable) begin
            state_q   <= IDLE;
            fct_req_q <= 1'b0;
          end
        end
        UPDATE: begin
          state_q   <= IDLE;
          fct_req_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          fct_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Pending FCT count: commit in UPDATE, new owed FCT on each slot_free edge
  always_comb begin
    pending_d = pending_q;
    if (in_update) begin
      // pending_q >= 1 here, so the sum never exceeds the old value
      pending_d = pending_q - PEND_ONE + PWIDTH'(slot_edge);
    end else if (slot_edge && (pending_q != PEND_SAT)) begin
      pending_d = pending_q + PEND_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q   <= PEND_INIT;
      slot_free_q <= 1'b0;
    end else if (link_reset) begin
      pending_q   <= PEND_INIT;
      slot_free_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      slot_free_q <= slot_free;
    end
  end

  rx_credit_counter u_credit (
    .clock        (clock),
    .reset        (reset),
    .clear        (link_reset),
    .add8         (in_update),
    .sub1         (rx_char_valid),
    .credit       (outstanding_credit),
    .credit_error (credit_error)
  );

`ifdef RX_FCT_STATS_EN
  logic [15:0] fct_sent_q;

  // Count of committed FCTs, wraps naturally
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fct_sent_q <= '0;
    end else if (link_reset) begin
      fct_sent_q <= '0;
    end else if (in_update) begin
      fct_sent_q <= fct_sent_q + 16'd1;
    end
  end

  assign fct_sent_count = fct_sent_q;
`endif

  assign fct_req     = fct_req_q;
  assign pending_fct = pending_q;

endmodule
